// File: rtl/i2c_req_arbiter_if.sv
// Request/response bundle between the user requesters, the arbiter
// and the shared i2c_master command port.
//
// Signals:
//   req, req_addr, req_wdata, req_rw   per-requester command, packed by index
//   gnt, done, rd_data, busy           arbiter status back to the requesters
//   m_en, m_address, m_data_in,
//   m_read_write, m_data_out           shared i2c_master command/data port
//
// Modports:
//   master  arbiter side (drives grants and the i2c_master command inputs)
//   slave   environment side (requesters plus the i2c_master read data)
interface i2c_req_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [7*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   req_rw;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [7:0]         rd_data;
    logic               busy;
    logic               m_en;
    logic [6:0]         m_address;
    logic [7:0]         m_data_in;
    logic               m_read_write;
    logic [7:0]         m_data_out;

    modport master (
        input  req,
        input  req_addr,
        input  req_wdata,
        input  req_rw,
        input  m_data_out,
        output gnt,
        output done,
        output rd_data,
        output busy,
        output m_en,
        output m_address,
        output m_data_in,
        output m_read_write
    );

    modport slave (
        output req,
        output req_addr,
        output req_wdata,
        output req_rw,
        output m_data_out,
        input  gnt,
        input  done,
        input  rd_data,
        input  busy,
        input  m_en,
        input  m_address,
        input  m_data_in,
        input  m_read_write
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between N_REQ requesters.
// Latches the winner's command, issues it, times it, returns done/rd_data.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   i2c_req_arbiter_if.master:
//         req/req_addr/req_wdata/req_rw in, gnt/done/rd_data/busy out,
//         m_en/m_address/m_data_in/m_read_write out, m_data_out in
//
// Sequence: IDLE -> ISSUE (1) -> WAIT (XFER_CYCLES) -> CAPTURE (1)
//           -> GUARD (GUARD_CYCLES, skipped when 0) -> IDLE.
// All outputs are registers updated together with the state.
module i2c_req_arbiter #(
    parameter int N_REQ        = 2,
    parameter int XFER_CYCLES  = 400,
    parameter int GUARD_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    i2c_req_arbiter_if.master  bus
);
    localparam int MAX_C = (XFER_CYCLES > GUARD_CYCLES) ? XFER_CYCLES : GUARD_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int PW    = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        GUARD
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   cur;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [N_REQ-1:0] pick_oh;

    // Round-robin scan ptr, ptr+1, ... mod N_REQ. The loop runs in
    // reverse scan order so the last hit, i.e. the first in scan
    // order, is the one that sticks.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (bus.req[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            ptr              <= '0;
            cur              <= '0;
            bus.gnt          <= '0;
            bus.done         <= '0;
            bus.rd_data      <= '0;
            bus.busy         <= 1'b0;
            bus.m_en         <= 1'b0;
            bus.m_address    <= '0;
            bus.m_data_in    <= '0;
            bus.m_read_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        // The m_* registers double as the latched copy of
                        // the winner's command for the whole transaction.
                        state            <= ISSUE;
                        cur              <= pick;
                        bus.gnt          <= pick_oh;
                        bus.busy         <= 1'b1;
                        bus.m_en         <= 1'b1;
                        bus.m_address    <= bus.req_addr[7*pick +: 7];
                        bus.m_data_in    <= bus.req_wdata[8*pick +: 8];
                        bus.m_read_write <= bus.req_rw[pick];
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    bus.m_en <= 1'b0;
                    // Loaded one short so WAIT lasts exactly XFER_CYCLES.
                    cnt      <= CW'(XFER_CYCLES - 1);
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= CAPTURE;
                        bus.done <= bus.gnt;
                        if (bus.m_read_write) begin
                            bus.rd_data <= bus.m_data_out;
                        end
                        if (cur == PW'(N_REQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= cur + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    bus.done <= '0;
                    bus.gnt  <= '0;
                    if (GUARD_CYCLES == 0) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= GUARD;
                        cnt   <= CW'(GUARD_CYCLES - 1);
                    end
                end
                GUARD: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: a transaction-level model predicts
// each grant, its timing and its data; a monitor compares DUT pulses.
module tb_i2c_req_arbiter;
    localparam int N = 2;
    localparam int X = 20;
    localparam int G = 4;
    localparam logic [7:0] MDO = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_req_arbiter_if #(.N_REQ(N)) bus ();

    i2c_req_arbiter #(
        .N_REQ(N),
        .XFER_CYCLES(X),
        .GUARD_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic       rq  [N];
    logic [6:0] ad  [N];
    logic [7:0] wd  [N];
    logic       rwv [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req[i]              = rq[i];
            bus.req_addr[7*i +: 7]  = ad[i];
            bus.req_wdata[8*i +: 8] = wd[i];
            bus.req_rw[i]           = rwv[i];
        end
    end
    assign bus.m_data_out = MDO;

    typedef struct {
        int         w;
        logic [6:0] a;
        logic [7:0] d;
        logic       rw;
        int         en_c;
        int         done_c;
        logic [7:0] rd;
    } txn_t;

    txn_t en_q[$];
    txn_t dn_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ptr_m = 0;
    int free_at = 0;
    int busy_until = -1;
    logic [7:0] rd_m = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: the arbiter is free again X+G+3 edges after a grant;
    // on a free edge the first requester at or after ptr_m wins.
    always @(posedge clk) begin
        txn_t t;
        int w;
        cyc = cyc + 1;
        if (!rst) begin
            ptr_m = 0;
            free_at = cyc + 1;
            busy_until = -1;
            rd_m = 8'h00;
            en_q.delete();
            dn_q.delete();
        end else if (cyc >= free_at && (|bus.req)) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && bus.req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            end
            t.w = w;
            t.a = bus.req_addr[7*w +: 7];
            t.d = bus.req_wdata[8*w +: 8];
            t.rw = bus.req_rw[w];
            t.en_c = cyc;
            t.done_c = cyc + X + 1;
            if (t.rw) rd_m = MDO;
            t.rd = rd_m;
            en_q.push_back(t);
            ptr_m = (w + 1) % N;
            free_at = cyc + X + G + 3;
            busy_until = cyc + X + G + 1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            chk("busy", 32'(bus.busy), 32'(cyc <= busy_until));
            if (!(cyc <= busy_until)) chk("gnt_idle", 32'(bus.gnt), 32'(0));
            if (bus.m_en) begin
                if (en_q.size() == 0) begin
                    chk("m_en_unexpected", 32'(bus.m_en), 32'(0));
                end else begin
                    t = en_q.pop_front();
                    chk("en_cycle", 32'(cyc), 32'(t.en_c));
                    chk("en_gnt", 32'(bus.gnt), 32'(1 << t.w));
                    chk("en_addr", 32'(bus.m_address), 32'(t.a));
                    chk("en_data", 32'(bus.m_data_in), 32'(t.d));
                    chk("en_rw", 32'(bus.m_read_write), 32'(t.rw));
                    dn_q.push_back(t);
                end
            end else if (en_q.size() > 0 && en_q[0].en_c < cyc) begin
                chk("m_en_missing", 32'(bus.m_en), 32'(1));
                void'(en_q.pop_front());
            end
            if (|bus.done) begin
                if (dn_q.size() == 0) begin
                    chk("done_unexpected", 32'(bus.done), 32'(0));
                end else begin
                    t = dn_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(t.done_c));
                    chk("done_bits", 32'(bus.done), 32'(1 << t.w));
                    chk("done_gnt", 32'(bus.gnt), 32'(1 << t.w));
                    chk("rd_data", 32'(bus.rd_data), 32'(t.rd));
                    chk("held_addr", 32'(bus.m_address), 32'(t.a));
                    chk("held_data", 32'(bus.m_data_in), 32'(t.d));
                    chk("held_rw", 32'(bus.m_read_write), 32'(t.rw));
                end
            end else if (dn_q.size() > 0 && dn_q[0].done_c < cyc) begin
                chk("done_missing", 32'(|bus.done), 32'(1));
                void'(dn_q.pop_front());
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(0));
        chk({tag, "_done"}, 32'(bus.done), 32'(0));
        chk({tag, "_rd"}, 32'(bus.rd_data), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_men"}, 32'(bus.m_en), 32'(0));
        chk({tag, "_maddr"}, 32'(bus.m_address), 32'(0));
        chk({tag, "_mdin"}, 32'(bus.m_data_in), 32'(0));
        chk({tag, "_mrw"}, 32'(bus.m_read_write), 32'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(bus.busy), 32'(0));
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic [6:0] a, input logic [7:0] d,
                         input logic rw, input int drop_after);
        int n;
        @(negedge clk);
        rq[i] = 1'b1;
        ad[i] = a;
        wd[i] = d;
        rwv[i] = rw;
        n = 0;
        while (!bus.gnt[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("grant_timeout", 32'(bus.gnt[i]), 32'(1));
        ad[i] = 7'($urandom);
        wd[i] = 8'($urandom);
        rwv[i] = 1'($urandom);
        if (drop_after > 0) begin
            repeat (drop_after) @(negedge clk);
            rq[i] = 1'b0;
            ad[i] = 7'($urandom);
        end
        n = 0;
        while (!bus.done[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("done_timeout", 32'(bus.done[i]), 32'(1));
        rq[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last;
        logic [1:0] exp_g;
        for (int i = 0; i < N; i++) begin
            rq[i] = 1'b0;
            ad[i] = '0;
            wd[i] = '0;
            rwv[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check_zero("idle100");

        drive(0, 7'h20, 8'h3C, 1'b0, 0);
        wait_idle();
        chk("write_rd_stays", 32'(bus.rd_data), 32'(8'h00));

        drive(1, 7'h51, 8'h00, 1'b1, 0);
        wait_idle();
        chk("read_rd", 32'(bus.rd_data), 32'(MDO));

        @(negedge clk);
        rq[0] = 1'b1; ad[0] = 7'h11; wd[0] = 8'h5A; rwv[0] = 1'b0;
        rq[1] = 1'b1; ad[1] = 7'h22; wd[1] = 8'hC3; rwv[1] = 1'b1;
        last = -1;
        exp_g = 2'b01;
        for (int p = 0; p < 4; p++) begin
            n = 0;
            while (!bus.m_en && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("alt_timeout", 32'(bus.m_en), 32'(1));
            chk("alt_winner", 32'(bus.gnt), 32'(exp_g));
            if (last >= 0) chk("alt_gap", 32'(cyc - last), 32'(27));
            last = cyc;
            exp_g = ~exp_g;
            @(negedge clk);
        end
        n = 0;
        while (!(|bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        wait_idle();

        drive(0, 7'h33, 8'h44, 1'b0, 8);
        wait_idle();

        @(negedge clk);
        rq[0] = 1'b1; ad[0] = 7'h0F; wd[0] = 8'h77; rwv[0] = 1'b0;
        n = 0;
        while (!bus.m_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (11) @(negedge clk);
        rq[0] = 1'b0;
        rq[1] = 1'b1; ad[1] = 7'h12; wd[1] = 8'h00; rwv[1] = 1'b1;
        #2 rst = 1'b0;
        #1 check_zero("midreset");
        repeat (3) @(negedge clk);
        check_zero("rsthold");
        #2 rst = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(|bus.gnt) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_regrant", 32'(bus.gnt), 32'(2'b10));
        n = 0;
        while (!bus.done[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        rq[1] = 1'b0;
        wait_idle();

        fork
            begin
                for (int j = 0; j < 12; j++) begin
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    drive(0, 7'($urandom), 8'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0);
                end
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    drive(1, 7'($urandom), 8'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0);
                end
            end
        join
        wait_idle();
        repeat (3) @(negedge clk);
        chk("end_en_q", 32'(en_q.size()), 32'(0));
        chk("end_dn_q", 32'(dn_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
